// File: rtl/opb_register_simulink2ppc_snap.sv
// ---------------------------------------------------------------------------
// opb_register_simulink2ppc_snap
//
// Fabric-to-processor status register. A 32-bit word from the user fabric is
// captured into a holding register and served to software as an OPB slave.
// It also provides a sticky NEW flag, a software FREEZE and, optionally, a
// 16-bit saturating overrun counter.
//
// Optional feature macro: SIMULINK2PPC_OVERRUN_COUNT_EN
//   defined   -> overrun counter plus its clear bit in CTRL are built
//   undefined -> no counter; the count field reads 0 and the clear bit is inert
//
// Register map (byte offset within the decode window, OPB_ABus[28:29]):
//   0x0 DATA    RO  holding register; a read clears NEW
//   0x4 STATUS  RO  DBus[31]=NEW, DBus[30]=FREEZE, overrun count in DBus[0:15]
//   0x8 CTRL    RW  DBus[31]=FREEZE, DBus[30]=1 clears the count (reads 0);
//                   writes take effect only with BE[3]=1
//   0xC         reads 0, writes acked and ignored
//
// Ports:
//   OPB_Clk, OPB_Rst_n        clock, asynchronous active-low reset
//   OPB_ABus/BE/DBus/RNW      OPB master request (big-endian bit numbering)
//   OPB_select, OPB_seqAddr   transfer request, burst hint (ignored)
//   Sl_DBus, Sl_xferAck       registered read data and one-cycle acknowledge
//   Sl_errAck/retry/toutSup   tied low
//   user_data_in/valid        fabric word and its capture strobe
// ---------------------------------------------------------------------------
module opb_register_simulink2ppc_snap #(
  parameter logic [31:0] C_BASEADDR   = 32'h01060900,
  parameter logic [31:0] C_HIGHADDR   = 32'h010609FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic [31:0] user_data_in,
  input  logic        user_data_valid
);

  // Only 32-bit address/data buses exist for this block; the family string is
  // informational.
  localparam bit    unused_widths_ok = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32);
  localparam string unused_family    = C_FAMILY;

  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  state_t      state_reg, state_next;
  logic        accept;
  logic        hit;
  logic [1:0]  reg_sel;
  logic        rd_accept, wr_accept;
  logic        data_read, ctrl_write;
  logic        capture;
  logic        new_next;
  logic [31:0] rdata;
  logic [31:0] status_word;
  logic [31:0] dbus_reg;
  logic [31:0] hold_reg;
  logic        new_reg;
  logic        freeze_reg;

  assign hit     = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign reg_sel = OPB_ABus[28:29];

  // Bus FSM: a transfer is accepted in IDLE and acked for exactly one cycle.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (OPB_select && hit) begin
          accept     = 1'b1;
          state_next = ST_ACK;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign rd_accept  = accept && OPB_RNW;
  assign wr_accept  = accept && !OPB_RNW;
  assign data_read  = rd_accept && (reg_sel == 2'd0);
  assign ctrl_write = wr_accept && (reg_sel == 2'd2) && OPB_BE[3];

  // FREEZE is sampled pre-edge, so a strobe on the same edge as a freezing
  // CTRL write is still captured.
  assign capture = user_data_valid && !freeze_reg;

  // A capture on the same edge as a DATA read wins: the new word is unread.
  always_comb begin
    new_next = new_reg;
    if (capture) begin
      new_next = 1'b1;
    end else if (data_read) begin
      new_next = 1'b0;
    end
  end

`ifdef SIMULINK2PPC_OVERRUN_COUNT_EN
  logic [15:0] overrun_cnt_reg;
  logic        cnt_clear;
  logic        cnt_inc;

  assign cnt_clear = ctrl_write && OPB_DBus[30];
  // A capture is an overrun only if the previous word is still unread and is
  // not being consumed on this very edge.
  assign cnt_inc   = capture && new_reg && !data_read && (overrun_cnt_reg != 16'hFFFF);

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      overrun_cnt_reg <= '0;
    end else if (cnt_clear) begin
      overrun_cnt_reg <= '0;
    end else if (cnt_inc) begin
      overrun_cnt_reg <= overrun_cnt_reg + 16'd1;
    end
  end

  // NEW and FREEZE occupy the two LSBs, so the count sits in the upper half.
  assign status_word = {overrun_cnt_reg, 14'b0, freeze_reg, new_reg};
`else
  assign status_word = {30'b0, freeze_reg, new_reg};
`endif

  // rdata is numbered [31:0]; bit n lands on DBus[31-n].
  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0:    rdata = hold_reg;
      2'd1:    rdata = status_word;
      2'd2:    rdata[0] = freeze_reg;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      dbus_reg   <= '0;
      hold_reg   <= '0;
      new_reg    <= 1'b0;
      freeze_reg <= 1'b0;
    end else begin
      // Loaded only on a read accept, so it is zero whenever no ack is shown.
      dbus_reg <= rd_accept ? rdata : '0;
      if (capture) begin
        hold_reg <= user_data_in;
      end
      new_reg <= new_next;
      if (ctrl_write) begin
        freeze_reg <= OPB_DBus[31];
      end
    end
  end

  assign Sl_DBus    = dbus_reg;
  assign Sl_xferAck = (state_reg == ST_ACK);
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// ---------------------------------------------------------------------------
// tb_opb_register_simulink2ppc_snap
//
// Self-checking bench for opb_register_simulink2ppc_snap. Bus transfers push
// their expected read data into a scoreboard queue; a monitor pops and
// compares on every ack. A table of vectors covers the register map, followed
// by hand-written multi-cycle corner cases. Overrun checks that depend on
// SIMULINK2PPC_OVERRUN_COUNT_EN follow the same macro.
// ---------------------------------------------------------------------------
module tb_opb_register_simulink2ppc_snap;

  localparam logic [31:0] A_DATA = 32'h01060900;
  localparam logic [31:0] A_STAT = 32'h01060904;
  localparam logic [31:0] A_CTRL = 32'h01060908;
  localparam logic [31:0] A_RSV  = 32'h0106090C;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst_n = 1'b0;
  logic [0:31] OPB_ABus = '0;
  logic [0:3]  OPB_BE = 4'hF;
  logic [0:31] OPB_DBus = '0;
  logic        OPB_RNW = 1'b1;
  logic        OPB_select = 1'b0;
  logic        OPB_seqAddr = 1'b0;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_in = '0;
  logic        user_data_valid = 1'b0;

  always #5 OPB_Clk = ~OPB_Clk;

  opb_register_simulink2ppc_snap dut (
    .OPB_Clk        (OPB_Clk),
    .OPB_Rst_n      (OPB_Rst_n),
    .OPB_ABus       (OPB_ABus),
    .OPB_BE         (OPB_BE),
    .OPB_DBus       (OPB_DBus),
    .OPB_RNW        (OPB_RNW),
    .OPB_select     (OPB_select),
    .OPB_seqAddr    (OPB_seqAddr),
    .Sl_DBus        (Sl_DBus),
    .Sl_xferAck     (Sl_xferAck),
    .Sl_errAck      (Sl_errAck),
    .Sl_retry       (Sl_retry),
    .Sl_toutSup     (Sl_toutSup),
    .user_data_in   (user_data_in),
    .user_data_valid(user_data_valid)
  );

  typedef struct {
    logic [31:0] data;
    string       name;
  } exp_t;

  typedef struct {
    logic        strobe;
    logic [31:0] udata;
    logic [31:0] addr;
    logic        rnw;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
    string       name;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  task automatic expect_ack(input logic [31:0] data, input string name);
    exp_t e;
    e.data = data;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge OPB_Clk);
      check("tie_offs", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
      if (Sl_xferAck === 1'b1) begin
        ack_count++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack actual=ack required=no_ack data=%08h", Sl_DBus);
        end else begin
          e = sb_q.pop_front();
          $display("ack %-20s data=%08h expected=%08h", e.name, Sl_DBus, e.data);
          check(e.name, Sl_DBus, e.data);
        end
      end else begin
        check("idle_dbus", Sl_DBus, 32'h0);
      end
    end
  endtask

  // Bounded wait for every queued ack to be seen by the monitor.
  task automatic wait_drain(input string name);
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) begin
      @(negedge OPB_Clk);
      #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_ack_timeout actual=%0d_pending required=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // One transfer; optionally a user strobe on the same accept edge.
  task automatic bus_op(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                        input logic [3:0] be, input logic coin_valid, input logic [31:0] coin_data,
                        input logic [31:0] exp, input string name);
    @(posedge OPB_Clk);
    #1;
    OPB_ABus        = addr;
    OPB_RNW         = rnw;
    OPB_DBus        = wdata;
    OPB_BE          = be;
    OPB_select      = 1'b1;
    user_data_valid = coin_valid;
    user_data_in    = coin_data;
    expect_ack(exp, name);
    @(posedge OPB_Clk);
    #1;
    OPB_select      = 1'b0;
    OPB_DBus        = '0;
    OPB_RNW         = 1'b1;
    user_data_valid = 1'b0;
    wait_drain(name);
  endtask

  task automatic strobe(input logic [31:0] d, input int n);
    @(posedge OPB_Clk);
    #1;
    user_data_valid = 1'b1;
    user_data_in    = d;
    repeat (n) @(posedge OPB_Clk);
    #1;
    user_data_valid = 1'b0;
  endtask

  task automatic hold_select(input logic [31:0] addr, input int n);
    @(posedge OPB_Clk);
    #1;
    OPB_ABus   = addr;
    OPB_RNW    = 1'b1;
    OPB_select = 1'b1;
    repeat (n) @(posedge OPB_Clk);
    #1;
    OPB_select = 1'b0;
  endtask

  vec_t vecs[25];
  logic [31:0] ovr_exp;
  int          acks_before;

  initial begin
    vecs[0]  = '{1'b0, 32'h0,        A_DATA, 1'b1, 32'h0,        4'hF, 32'h0,        "rst_data"};
    vecs[1]  = '{1'b0, 32'h0,        A_STAT, 1'b1, 32'h0,        4'hF, 32'h0,        "rst_status"};
    vecs[2]  = '{1'b0, 32'h0,        A_CTRL, 1'b1, 32'h0,        4'hF, 32'h0,        "rst_ctrl"};
    vecs[3]  = '{1'b1, 32'hDEADBEEF, A_STAT, 1'b1, 32'h0,        4'hF, 32'h1,        "new_set"};
    vecs[4]  = '{1'b0, 32'h0,        A_DATA, 1'b1, 32'h0,        4'hF, 32'hDEADBEEF, "data_read"};
    vecs[5]  = '{1'b0, 32'h0,        A_STAT, 1'b1, 32'h0,        4'hF, 32'h0,        "new_cleared"};
    vecs[6]  = '{1'b0, 32'h0,        A_CTRL, 1'b0, 32'h1,        4'hF, 32'h0,        "freeze_on"};
    vecs[7]  = '{1'b0, 32'h0,        A_CTRL, 1'b1, 32'h0,        4'hF, 32'h1,        "ctrl_rd"};
    vecs[8]  = '{1'b0, 32'h0,        A_STAT, 1'b1, 32'h0,        4'hF, 32'h2,        "status_freeze"};
    vecs[9]  = '{1'b1, 32'h12345678, A_DATA, 1'b1, 32'h0,        4'hF, 32'hDEADBEEF, "frozen_data"};
    vecs[10] = '{1'b0, 32'h0,        A_STAT, 1'b1, 32'h0,        4'hF, 32'h2,        "frozen_new"};
    vecs[11] = '{1'b0, 32'h0,        A_CTRL, 1'b0, 32'h0,        4'hE, 32'h0,        "ctrl_be3_off"};
    vecs[12] = '{1'b0, 32'h0,        A_CTRL, 1'b1, 32'h0,        4'hF, 32'h1,        "ctrl_kept"};
    vecs[13] = '{1'b0, 32'h0,        A_CTRL, 1'b0, 32'h0,        4'hF, 32'h0,        "freeze_off"};
    vecs[14] = '{1'b1, 32'h12345678, A_DATA, 1'b1, 32'h0,        4'hF, 32'h12345678, "thaw_capture"};
    vecs[15] = '{1'b0, 32'h0,        A_RSV,  1'b1, 32'h0,        4'hF, 32'h0,        "rsv_read"};
    vecs[16] = '{1'b0, 32'h0,        A_DATA, 1'b0, 32'hFFFFFFFF, 4'hF, 32'h0,        "data_wr"};
    vecs[17] = '{1'b0, 32'h0,        A_DATA, 1'b1, 32'h0,        4'hF, 32'h12345678, "data_wr_ignored"};
    vecs[18] = '{1'b0, 32'h0,        A_RSV,  1'b0, 32'hFFFFFFFF, 4'hF, 32'h0,        "rsv_wr"};
    vecs[19] = '{1'b1, 32'h00000001, A_STAT, 1'b1, 32'h0,        4'hF, 32'h1,        "new_again"};
    vecs[20] = '{1'b0, 32'h0,        32'h010609F0, 1'b1, 32'h0,  4'hF, 32'h1,        "alias_data_top"};
    vecs[21] = '{1'b0, 32'h0,        32'h010609FC, 1'b1, 32'h0,  4'hF, 32'h0,        "alias_rsv_top"};
    vecs[22] = '{1'b0, 32'h0,        A_STAT, 1'b1, 32'h0,        4'hF, 32'h0,        "alias_cleared_new"};
    vecs[23] = '{1'b0, 32'h0,        A_STAT, 1'b0, 32'hFFFFFFFF, 4'hF, 32'h0,        "stat_wr"};
    vecs[24] = '{1'b0, 32'h0,        A_CTRL, 1'b1, 32'h0,        4'hF, 32'h0,        "ctrl_after_stat_wr"};

    fork
      monitor();
    join_none

    // Reset state while reset is held.
    repeat (2) @(posedge OPB_Clk);
    #1;
    check("rst_ack", {31'b0, Sl_xferAck}, 32'h0);
    check("rst_dbus", Sl_DBus, 32'h0);
    OPB_Rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      if (vecs[i].strobe) strobe(vecs[i].udata, 1);
      bus_op(vecs[i].addr, vecs[i].rnw, vecs[i].wdata, vecs[i].be, 1'b0, 32'h0,
             vecs[i].exp, vecs[i].name);
    end

    // Capture and DATA read on the same accept edge.
    strobe(32'h00000001, 1);
    bus_op(A_DATA, 1'b1, 32'h0, 4'hF, 1'b1, 32'hAAAA5555, 32'h00000001, "collision_old");
    bus_op(A_STAT, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 32'h00000001, "collision_new");
    bus_op(A_DATA, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 32'hAAAA5555, "collision_hold");

    // Freezing write on the same edge as a strobe still captures.
    bus_op(A_CTRL, 1'b0, 32'h1, 4'hF, 1'b1, 32'h5A5A5A5A, 32'h0, "freeze_edge_wr");
    bus_op(A_DATA, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 32'h5A5A5A5A, "freeze_edge_cap");
    bus_op(A_CTRL, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0, 32'h0, "unfreeze");

    // Three strobes without a read: two overruns.
    strobe(32'h11, 1);
    strobe(32'h22, 1);
    strobe(32'h33, 1);
`ifdef SIMULINK2PPC_OVERRUN_COUNT_EN
    ovr_exp = 32'h00020001;
`else
    ovr_exp = 32'h00000001;
`endif
    bus_op(A_STAT, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, ovr_exp, "overrun_two");
    bus_op(A_CTRL, 1'b0, 32'h2, 4'hF, 1'b0, 32'h0, 32'h0, "ovr_clear_wr");
    bus_op(A_STAT, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 32'h00000001, "ovr_cleared");
    bus_op(A_CTRL, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 32'h0, "clear_bit_reads0");
`ifdef SIMULINK2PPC_OVERRUN_COUNT_EN
    strobe(32'h44, 65600);
    bus_op(A_STAT, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 32'hFFFF0001, "ovr_saturated");
`endif
    // Overrun and clear on the same edge: clear wins.
    bus_op(A_CTRL, 1'b0, 32'h2, 4'hF, 1'b1, 32'h44, 32'h0, "clear_vs_inc_wr");
    bus_op(A_STAT, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 32'h00000001, "clear_vs_inc");

    // Select held for six edges: exactly three single-cycle acks.
    acks_before = ack_count;
    repeat (3) expect_ack(32'h44, "held_ack");
    hold_select(A_DATA, 6);
    wait_drain("held_select");
    @(negedge OPB_Clk);
    #1;
    check("held_ack_count", ack_count - acks_before, 32'd3);

    // Misses above and below the window never ack.
    acks_before = ack_count;
    hold_select(32'h01060A00, 3);
    hold_select(32'h010608FC, 3);
    repeat (2) @(negedge OPB_Clk);
    #1;
    check("miss_ack_count", ack_count - acks_before, 32'd0);

    // Reset during ACK drops the ack at once and clears all state.
    strobe(32'hCAFEF00D, 1);
    bus_op(A_CTRL, 1'b0, 32'h1, 4'hF, 1'b0, 32'h0, 32'h0, "freeze_pre_rst");
    @(posedge OPB_Clk);
    #1;
    OPB_ABus   = A_STAT;
    OPB_RNW    = 1'b1;
    OPB_select = 1'b1;
    @(posedge OPB_Clk);
    #1;
    OPB_select = 1'b0;
    check("ack_pre_rst", {31'b0, Sl_xferAck}, 32'h1);
    check("dbus_pre_rst", Sl_DBus, 32'h00000003);
    OPB_Rst_n = 1'b0;
    #1;
    check("ack_in_rst", {31'b0, Sl_xferAck}, 32'h0);
    check("dbus_in_rst", Sl_DBus, 32'h0);
    repeat (2) @(posedge OPB_Clk);
    #1;
    OPB_Rst_n = 1'b1;
    bus_op(A_DATA, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 32'h0, "post_rst_data");
    bus_op(A_STAT, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 32'h0, "post_rst_status");

    repeat (2) @(posedge OPB_Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
